// File: rtl/sin_voice_scheduler.sv
// rtl/sin_voice_scheduler.sv - time-multiplexed sine voice scheduler sharing one sine ROM
//
// Ports:
//   clk_i, rst_i      clock (rising edge) and asynchronous active-high reset
//   sample_tick_i     one-cycle pulse starting a round over all channels
//   mult_i, mult_en_i per-channel phase increment and its enable (disabled steps by 1)
//   level_i           per-channel unsigned 8-bit attenuation level
//   overrun_clr_i     clears the sticky overrun flag
//   rom_addr_o        address to the shared ROM (1-cycle read latency)
//   rom_data_i        signed ROM word for the address of the previous cycle
//   data_o            attenuated per-channel samples, updated together
//   valid_o           pulse in the cycle data_o has just been updated
//   busy_o            a round is in progress
//   overrun_o         sticky: a tick arrived while a round was in progress

module sin_voice_scheduler #(
  parameter int CHANNELS = 4,
  parameter int DWIDTH   = 16,
  parameter int RES      = 256,
  localparam int AW      = $clog2(RES)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sample_tick_i,
  input  logic [CHANNELS*AW-1:0]     mult_i,
  input  logic [CHANNELS-1:0]        mult_en_i,
  input  logic [CHANNELS*8-1:0]      level_i,
  input  logic                       overrun_clr_i,
  output logic [AW-1:0]              rom_addr_o,
  input  logic [DWIDTH-1:0]          rom_data_i,
  output logic [CHANNELS*DWIDTH-1:0] data_o,
  output logic                       valid_o,
  output logic                       busy_o,
  output logic                       overrun_o
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = AW + 2;
  localparam int PW = DWIDTH + 9;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
  localparam logic [SW-1:0] RES_W   = SW'(RES);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;

  logic [AW-1:0]            phase_q  [CHANNELS];
  logic signed [DWIDTH-1:0] shadow_q [CHANNELS];

  // Controls of the channel currently being served.
  logic [AW-1:0] mult_ch;
  logic [7:0]    level_ch;
  logic          en_ch;

  logic [AW-1:0] inc;
  logic [SW-1:0] sum_raw, sum_1;
  logic [AW-1:0] phase_next;

  logic signed [PW-1:0]     rom_ext, lvl_ext, prod, prod_sh;
  logic signed [DWIDTH-1:0] atten;
  logic                     unused_prod_bits;

  always_comb begin
    mult_ch  = mult_i[int'(ch_q)*AW +: AW];
    level_ch = level_i[int'(ch_q)*8 +: 8];
    en_ch    = mult_en_i[ch_q];
    inc      = en_ch ? mult_ch : AW'(1);
    // mult can reach 2^AW-1, which may exceed RES when RES is not a power of two,
    // so the sum can need up to two modulus corrections.
    sum_raw  = {2'b00, phase_q[ch_q]} + {2'b00, inc};
    sum_1    = (sum_raw >= RES_W) ? (sum_raw - RES_W) : sum_raw;
    phase_next = (sum_1 >= RES_W) ? AW'(sum_1 - RES_W) : AW'(sum_1);
  end

  // Signed sample times unsigned level; the shift is arithmetic, giving floor division.
  always_comb begin
    rom_ext = {{9{rom_data_i[DWIDTH-1]}}, rom_data_i};
    lvl_ext = {{(DWIDTH + 1){1'b0}}, level_ch};
    prod    = rom_ext * lvl_ext;
    prod_sh = prod >>> 8;
    atten   = prod_sh[DWIDTH-1:0];
  end

  assign unused_prod_bits = ^prod_sh[PW-1:DWIDTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        if (sample_tick_i) begin
          state_d = ADDR;
          ch_d    = '0;
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        if (ch_q == LAST_CH) begin
          state_d = DONE;
        end else begin
          state_d = ADDR;
          ch_d    = ch_q + CW'(1);
        end
      end
      DONE: begin
        if (sample_tick_i) begin
          state_d = ADDR;
          ch_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid_o = (state_q == DONE);
  assign busy_o  = (state_q == ADDR) || (state_q == DATA);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rom_addr_o <= '0;
      data_o     <= '0;
      overrun_o  <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        phase_q[k]  <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      // The address is registered on entry to ADDR so it is stable for the whole
      // ADDR cycle and simply holds afterwards.
      if (state_d == ADDR) begin
        rom_addr_o <= phase_q[ch_d];
      end
      if (state_q == DATA) begin
        phase_q[ch_q]  <= phase_next;
        shadow_q[ch_q] <= atten;
        // The last channel's sample is still in flight, so it bypasses the shadow
        // to land in data_o together with the others.
        if (ch_q == LAST_CH) begin
          for (int k = 0; k < CHANNELS; k++) begin
            data_o[k*DWIDTH +: DWIDTH] <= (k == CHANNELS - 1) ? atten : shadow_q[k];
          end
        end
      end
      if (sample_tick_i && busy_o) begin
        overrun_o <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sin_voice_scheduler.sv
// tb/tb_sin_voice_scheduler.sv - self-checking bench for sin_voice_scheduler

module tb_sin_voice_scheduler;

  localparam int C   = 4;
  localparam int DW  = 16;
  localparam int RES = 256;
  localparam int AW  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            sample_tick = 1'b0;
  logic [C*AW-1:0] mult = '0;
  logic [C-1:0]    mult_en = '0;
  logic [C*8-1:0]  level = '0;
  logic            overrun_clr = 1'b0;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [C*DW-1:0] data_o;
  logic            valid_o;
  logic            busy_o;
  logic            overrun_o;

  logic signed [DW-1:0] rom_tbl [RES];
  logic [DW-1:0]        rom_q;

  sin_voice_scheduler #(.CHANNELS(C), .DWIDTH(DW), .RES(RES)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sample_tick_i (sample_tick),
    .mult_i        (mult),
    .mult_en_i     (mult_en),
    .level_i       (level),
    .overrun_clr_i (overrun_clr),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_tbl[rom_addr];
  assign rom_data = rom_q;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: a round is a position counter p, 0..2C-1 busy (even = address
  // slot of channel p/2, odd = data slot), p == 2C is the completion cycle.
  bit          act;
  int          p;
  int          phase_m  [C];
  int          shadow_m [C];
  logic [63:0] data_m;
  bit          ovr_m;
  int          addr_m;
  int          edge_n = 0;
  int          valid_edges [$];
  int          obs_addr [C];

  task automatic model_reset();
    act    = 1'b0;
    p      = 0;
    ovr_m  = 1'b0;
    addr_m = 0;
    data_m = '0;
    for (int k = 0; k < C; k++) begin
      phase_m[k]  = 0;
      shadow_m[k] = 0;
    end
  endtask

  function automatic int floor_atten(input int rd, input int lvl);
    int prod;
    int q;
    prod = rd * lvl;
    q    = prod / 256;
    if (prod < 0 && (prod % 256) != 0) q = q - 1;
    return q;
  endfunction

  always @(posedge clk) begin : model
    int  k;
    int  inc;
    bit  busy_before;
    edge_n++;
    if (rst) begin
      model_reset();
    end else begin
      busy_before = act && (p < 2*C);
      if (act && (p % 2) == 1) begin
        k = (p - 1) / 2;
        shadow_m[k] = floor_atten(int'(rom_tbl[phase_m[k]]), int'(level[k*8 +: 8]));
        inc = mult_en[k] ? int'(mult[k*AW +: AW]) : 1;
        phase_m[k] = (phase_m[k] + inc) % RES;
        if (k == C - 1) begin
          for (int j = 0; j < C; j++) data_m[j*16 +: 16] = 16'(shadow_m[j]);
        end
      end
      if (sample_tick && busy_before) ovr_m = 1'b1;
      else if (overrun_clr) ovr_m = 1'b0;
      if (act && p < 2*C) begin
        p++;
      end else if (sample_tick) begin
        act = 1'b1;
        p   = 0;
      end else begin
        act = 1'b0;
      end
      if (act && p < 2*C && (p % 2) == 0) addr_m = phase_m[p/2];
    end
  end

  always @(negedge clk) begin
    check("valid_o", longint'(valid_o), longint'(act && p == 2*C));
    check("busy_o", longint'(busy_o), longint'(act && p < 2*C));
    check("overrun_o", longint'(overrun_o), longint'(ovr_m));
    check("rom_addr_o", longint'(rom_addr), longint'(addr_m));
    check("data_o", longint'(data_o), longint'(data_m));
    if (valid_o) valid_edges.push_back(edge_n);
    if (act && p < 2*C && (p % 2) == 0) obs_addr[p/2] = int'(rom_addr);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_valid", longint'(valid_o), 0);
    check("rst_busy", longint'(busy_o), 0);
    check("rst_overrun", longint'(overrun_o), 0);
    check("rst_addr", longint'(rom_addr), 0);
    check("rst_data", longint'(data_o), 0);
    step(1);
    rst = 1'b0;
  endtask

  task automatic tick(output int e);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    e = edge_n;
  endtask

  function automatic int ch_sample(input int k);
    logic [DW-1:0] w;
    w = data_o[k*DW +: DW];
    return int'($signed(w));
  endfunction

  int e0, e1, e2;
  int exp35 [4] = '{0, 100, 200, 44};

  initial begin
    #1;
    do_reset();

    // Single round, ROM = addr*16, step by 1, full level.
    for (int a = 0; a < RES; a++) rom_tbl[a] = 16'(a * 16);
    mult_en = '0;
    mult    = '0;
    level   = {4{8'd255}};
    valid_edges.delete();
    tick(e0);
    step(12);
    for (int k = 0; k < C; k++) check("r1_addr", obs_addr[k], 0);
    check("r1_valid_count", valid_edges.size(), 1);
    check("r1_valid_edge", valid_edges[0] - e0, 8);
    check("r1_data", longint'(data_o), 0);
    tick(e1);
    step(12);
    for (int k = 0; k < C; k++) check("r2_addr", obs_addr[k], 1);
    check("r2_ch0", ch_sample(0), 15);

    // Channel 1 steps by 100, ticks 20 cycles apart.
    do_reset();
    mult_en = 4'b0010;
    mult    = 32'h0000_6400;
    for (int r = 0; r < 4; r++) begin
      tick(e0);
      step(19);
      check("mult_ch1_addr", obs_addr[1], exp35[r]);
      check("mult_ch0_addr", obs_addr[0], r);
    end

    // Attenuation corner cases on the most negative word.
    do_reset();
    for (int a = 0; a < RES; a++) rom_tbl[a] = 16'sh8000;
    mult_en = '0;
    level   = {8'd1, 8'd255, 8'd0, 8'd128};
    tick(e0);
    step(12);
    check("atten_128", ch_sample(0), -16384);
    check("atten_0", ch_sample(1), 0);
    check("atten_255", ch_sample(2), -32640);
    check("atten_1", ch_sample(3), -128);

    // Tick during a round: ignored, flags overrun; set beats clear.
    do_reset();
    for (int a = 0; a < RES; a++) rom_tbl[a] = 16'($urandom);
    level   = 32'($urandom);
    valid_edges.delete();
    tick(e0);
    step(2);
    tick(e1);
    step(10);
    check("ovr_valid_count", valid_edges.size(), 1);
    check("ovr_valid_edge", valid_edges[0] - e0, 8);
    check("ovr_set", longint'(overrun_o), 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    check("ovr_clear", longint'(overrun_o), 0);
    tick(e2);
    step(2);
    sample_tick = 1'b1;
    overrun_clr = 1'b1;
    step(1);
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    check("ovr_set_wins", longint'(overrun_o), 1);
    step(10);

    // Reset in the middle of a round.
    do_reset();
    mult_en = 4'b1111;
    mult    = {4{8'd7}};
    valid_edges.delete();
    tick(e0);
    step(5);
    do_reset();
    step(10);
    check("midrst_no_valid", valid_edges.size(), 0);
    tick(e0);
    step(12);
    for (int k = 0; k < C; k++) check("midrst_addr", obs_addr[k], 0);

    // Tick in the completion cycle chains straight into the next round.
    do_reset();
    valid_edges.delete();
    tick(e0);
    step(8);
    tick(e1);
    step(12);
    check("b2b_valid_count", valid_edges.size(), 2);
    check("b2b_valid_1", valid_edges[0] - e0, 8);
    check("b2b_valid_2", valid_edges[1] - e0, 17);
    check("b2b_overrun", longint'(overrun_o), 0);

    // Random traffic against the model.
    do_reset();
    for (int a = 0; a < RES; a++) rom_tbl[a] = 16'($urandom);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        do_reset();
      end else begin
        sample_tick = ($urandom_range(0, 5) == 0);
        overrun_clr = ($urandom_range(0, 11) == 0);
        mult        = $urandom;
        mult_en     = 4'($urandom);
        level       = $urandom;
        step(1);
      end
    end
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    step(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
